downcounter: RTL and testbench
==============================

DOWNCOUNTER -- requirements
Module: downcounter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state is updated on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port load_valid, input, 1, a start value is offered on load_value.
REQ-005 The block SHALL have port load_ready, output, 1, the block can accept a load this cycle.
REQ-006 The block SHALL have port load_value, input, WIDTH, the start and reload value.
REQ-007 The block SHALL have port en, input, 1, count enable; it gates decrements in RUN only.
REQ-008 The block SHALL have port auto_reload, input, 1, reload instead of stopping at terminal count.
REQ-009 The block SHALL have port clear, input, 1, synchronous abort to IDLE.
REQ-010 The block SHALL have port count, output, WIDTH, the registered current count.
REQ-011 The block SHALL have port tc, output, 1, a registered one-cycle terminal-count pulse.
REQ-012 The block SHALL have port busy, output, 1, high while the state is RUN.
REQ-013 The block SHALL have port done, output, 1, high while the state is DONE.

Function
REQ-014 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-015 load_ready SHALL be 1 in IDLE and DONE and 0 in RUN; load_valid in RUN SHALL be ignored.
REQ-016 A load SHALL be accepted on a rising edge with load_valid=1 and load_ready=1:
- count <= load_value and reload_reg <= load_value.
- Next state is RUN if load_value != 0, otherwise DONE.
REQ-017 A load of 0 SHALL assert tc for the single cycle after acceptance, with count=0.
REQ-018 In RUN with en=1 and count > 1, count SHALL decrement by 1 per edge; with en=0, count and state SHALL hold.
REQ-019 In RUN with en=1, count=1 and auto_reload=0:
- count <= 0, state <= DONE, tc <= 1 for exactly one cycle.
REQ-020 In RUN with en=1, count=1 and auto_reload=1:
- count <= reload_reg, the state stays RUN, tc <= 1 for one cycle.
- In this mode count never shows 0.
REQ-021 auto_reload SHALL be sampled only at the count=1 decision edge; it may change freely at other times.
REQ-022 In DONE, count SHALL hold 0 and tc SHALL be 0 after its single pulse, until a new load or clear.
REQ-023 clear=1 SHALL, on the next edge, force state IDLE, count 0 and tc 0 from any state.
REQ-024 When clear and an accepted load occur on the same edge, clear SHALL win and the load SHALL be discarded.
REQ-025 Latency SHALL be: a load accepted at edge N shows load_value on count after edge N, and the first decrement occurs at edge N+1 if en=1.
REQ-026 All arithmetic SHALL be unsigned WIDTH-bit and count SHALL never wrap below 0; load_value = 2^WIDTH-1 SHALL count the full range.

Reset
REQ-027 When rst=1, the block SHALL set asynchronously:
- state IDLE, count 0, reload_reg 0, tc 0, busy 0, done 0, load_ready 1.
REQ-028 After rst is deasserted, the first load SHALL be accepted on the first rising edge with load_valid=1.

Structure
REQ-029 Package downcounter_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default-width constant (4).
REQ-030 The block SHALL be a single flat module with no sub-module; outputs busy, done and load_ready SHALL be decoded from the state register.

Verification
REQ-031 The bench SHALL check a plain countdown:
- Stimulus: load 5, en=1 held, auto_reload=0.
- Response: count 5,4,3,2,1,0; tc high only in the cycle count first shows 0; then done=1, busy=0.
REQ-032 The bench SHALL check auto-reload:
- Stimulus: load 3, en=1, auto_reload=1.
- Response: count 3,2,1,3,2,1,...; tc pulses in each cycle count returns to 3; done stays 0.
REQ-033 The bench SHALL check enable gaps:
- Stimulus: load 4, then en pattern 1,0,0,1 over four edges.
- Response: count 3,3,3,2; tc stays 0.
REQ-034 The bench SHALL check a zero load:
- Stimulus: load 0 from IDLE.
- Response: next cycle done=1, tc=1 for one cycle, count=0; a load of 15 afterwards is accepted and reaches 0 after 15 enabled edges.
REQ-035 The bench SHALL check reset mid-operation:
- Stimulus: load 9, 3 enabled edges (count=6), then rst pulsed between clock edges.
- Response: count=0, busy=0 and tc=0 immediately, without waiting for a clock edge.
REQ-036 The bench SHALL check load/clear interactions:
- Stimulus 1: load_valid=1 with value 7 during RUN. Response: not accepted, load_ready=0, countdown unaffected.
- Stimulus 2: in DONE, clear=1 together with load_valid=1 and value 7. Response: IDLE, count 0.

Source files
------------

// File: rtl/downcounter_pkg.sv
// Shared types and constants for the loadable down-counter.
package downcounter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/downcounter.sv
// Loadable down-counter with enable, optional auto-reload, terminal-count pulse
// and synchronous clear; status outputs are decoded from the state register.
module downcounter
  import downcounter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             auto_reload,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state and next-datapath logic; clear overrides any load or count
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (load_valid) begin
            count_d  = load_value;
            reload_d = load_value;
            if (load_value != '0) begin
              state_d = RUN;
            end else begin
              state_d = DONE;
              tc_d    = 1'b1;
            end
          end
        end
        RUN: begin
          if (en) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else if (auto_reload) begin
              count_d = reload_q;
              tc_d    = 1'b1;
            end else begin
              count_d = '0;
              state_d = DONE;
              tc_d    = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign count      = count_q;
  assign tc         = tc_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign load_ready = (state_q != RUN);

endmodule

// File: tb/tb_downcounter.sv
// Directed table-driven bench for downcounter plus hand-written sequences for
// zero load, full-range count and asynchronous reset.
module tb_downcounter;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_value;
  logic       en;
  logic       auto_reload;
  logic       clear;
  logic [3:0] count;
  logic       tc;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  downcounter #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_value  (load_value),
    .en          (en),
    .auto_reload (auto_reload),
    .clear       (clear),
    .count       (count),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       lv;
    logic [3:0] val;
    logic       en;
    logic       ar;
    logic       clr;
    int         e_cnt;
    int         e_tc;
    int         e_busy;
    int         e_done;
    int         e_ready;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int idx, input int e_cnt, input int e_tc,
                           input int e_busy, input int e_done, input int e_ready);
    check({name, ".count"}, idx, int'(count), e_cnt);
    check({name, ".tc"}, idx, int'(tc), e_tc);
    check({name, ".busy"}, idx, int'(busy), e_busy);
    check({name, ".done"}, idx, int'(done), e_done);
    check({name, ".load_ready"}, idx, int'(load_ready), e_ready);
  endtask

  // Drive inputs, then sample 1 time unit after the next rising edge
  task automatic apply(input logic lv, input logic [3:0] val, input logic e,
                       input logic ar, input logic clr);
    load_valid  = lv;
    load_value  = val;
    en          = e;
    auto_reload = ar;
    clear       = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // lv val en ar clr | count tc busy done ready
    vecs[0]  = '{1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 5, 0, 1, 0, 0};  // plain countdown
    vecs[1]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4, 0, 1, 0, 0};
    vecs[2]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 3, 0, 1, 0, 0};
    vecs[3]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 2, 0, 1, 0, 0};
    vecs[4]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1, 0, 1, 0, 0};
    vecs[5]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1, 1};
    vecs[6]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1, 1};
    vecs[7]  = '{1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 3, 0, 1, 0, 0};  // auto-reload
    vecs[8]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 2, 0, 1, 0, 0};
    vecs[9]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1, 0, 1, 0, 0};
    vecs[10] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 3, 1, 1, 0, 0};
    vecs[11] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 2, 0, 1, 0, 0};
    vecs[12] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1, 0, 1, 0, 0};
    vecs[13] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 3, 1, 1, 0, 0};
    vecs[14] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 2, 0, 1, 0, 0};  // auto_reload dropped
    vecs[15] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1, 0, 1, 0, 0};
    vecs[16] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1, 1};
    vecs[17] = '{1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 4, 0, 1, 0, 0};  // enable gaps
    vecs[18] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 3, 0, 1, 0, 0};
    vecs[19] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3, 0, 1, 0, 0};
    vecs[20] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3, 0, 1, 0, 0};
    vecs[21] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 2, 0, 1, 0, 0};
    vecs[22] = '{1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1, 0, 1, 0, 0};  // load ignored in RUN
    vecs[23] = '{1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1, 1};
    vecs[24] = '{1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 1};  // clear beats load
    vecs[25] = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 2, 0, 1, 0, 0};
    vecs[26] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1};  // clear in RUN

    rst         = 1'b1;
    load_valid  = 1'b0;
    load_value  = 4'd0;
    en          = 1'b0;
    auto_reload = 1'b0;
    clear       = 1'b0;
    #12;
    check_all("reset", 0, 0, 0, 0, 0, 1);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].lv, vecs[i].val, vecs[i].en, vecs[i].ar, vecs[i].clr);
      check_all("vec", i, vecs[i].e_cnt, vecs[i].e_tc, vecs[i].e_busy,
                vecs[i].e_done, vecs[i].e_ready);
    end

    // Zero load from IDLE: straight to DONE with a single tc pulse
    apply(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    check_all("zero_load", 0, 0, 1, 0, 1, 1);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check_all("zero_load", 1, 0, 0, 0, 1, 1);

    // Full-range load of 15 reaches 0 after 15 enabled edges
    apply(1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
    check_all("full_load", 0, 15, 0, 1, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      check("full.count", i, int'(count), 15 - i);
      check("full.tc", i, int'(tc), (i == 15) ? 1 : 0);
    end
    check("full.done", 0, int'(done), 1);

    // Asynchronous reset between edges while running
    apply(1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check_all("pre_rst", 0, 6, 0, 1, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 1);
    #1;
    rst = 1'b0;

    // First load after reset is accepted on the first edge
    apply(1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    check_all("post_rst", 0, 2, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
